// File: rtl/int_pkg.sv
// int_pkg: shared FSM encoding and default constants for the interrupt dispatcher
package int_pkg;
  localparam int MAX_IRQ = 8;
  localparam logic [15:0] VEC_BASE_DEF = 16'h0040;
  localparam logic [15:0] VEC_STRIDE_DEF = 16'd8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_DISPATCH = 2'd2} state_t;
endpackage

// File: rtl/prio_enc_lsb.sv
// prio_enc_lsb: lowest-set-bit encoder returning the index and an any-set flag
module prio_enc_lsb #(
  parameter int N = 8,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) o_idx = i_vec[i] ? IW'(i) : o_idx;
  end
  assign o_valid = |i_vec;
endmodule

// File: rtl/int_dispatch_unit.sv
// int_dispatch_unit: IF/IE/IME registers, fixed-priority arbitration and req/ack vector dispatch
module int_dispatch_unit
  import int_pkg::*;
#(
  parameter int          NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic               clk4_2,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               if_wr,
  input  logic [NUM_IRQ-1:0] if_wdata,
  input  logic               ie_wr,
  input  logic [NUM_IRQ-1:0] ie_wdata,
  output logic [NUM_IRQ-1:0] if_rdata,
  output logic [NUM_IRQ-1:0] ie_rdata,
  input  logic               ime_set,
  input  logic               ime_reset,
  input  logic               reti,
  input  logic               instr_boundary,
  output logic               int_req,
  input  logic               int_ack,
  output logic               vec_valid,
  output logic [15:0]        vector,
  output logic [NUM_IRQ-1:0] irq_clear,
  output logic               ime,
  output logic               wake
);
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  if (NUM_IRQ < 1 || NUM_IRQ > MAX_IRQ) begin : g_bad_num_irq
    $error("NUM_IRQ out of range");
  end
  state_t r_state, w_next;
  logic [NUM_IRQ-1:0] r_if, r_ie, r_irq_clear, w_pend, w_if_base, w_arb, w_clr;
  logic [15:0] r_vector, w_vec;
  logic [IW-1:0] w_idx;
  logic r_ime, r_ei_pend, r_vec_valid, w_valid, w_ack;
  assign w_pend = r_if & r_ie;
  // arbitration sees a same-cycle IF write so a cancelling write yields an empty dispatch
  assign w_if_base = if_wr ? if_wdata : r_if;
  assign w_arb = w_if_base & r_ie;
  prio_enc_lsb #(.N(NUM_IRQ)) u_enc (.i_vec(w_arb), .o_idx(w_idx), .o_valid(w_valid));
  assign w_ack = (r_state == ST_REQ) && int_ack;
  assign w_clr = (w_ack && w_valid) ? NUM_IRQ'(1) << w_idx : '0;
  assign w_vec = w_valid ? VEC_BASE + 16'(w_idx) * VEC_STRIDE : 16'h0000;
  always_comb begin
    w_next = ST_IDLE;
    w_next = (r_state == ST_IDLE) ? ((r_ime && |w_pend) ? ST_REQ : ST_IDLE)
           : (r_state == ST_REQ)  ? (int_ack ? ST_DISPATCH : (!r_ime || !(|w_pend)) ? ST_IDLE : ST_REQ)
           : ST_IDLE;
  end
  always_ff @(posedge clk4_2) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_if        <= '0;
      r_ie        <= '0;
      r_ime       <= 1'b0;
      r_ei_pend   <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vector    <= 16'h0000;
      r_irq_clear <= '0;
    end else begin
      r_state     <= w_next;
      r_if        <= irq_req | (w_if_base & ~w_clr);
      r_ie        <= ie_wr ? ie_wdata : r_ie;
      r_ime       <= (ime_reset || w_ack) ? 1'b0 : (reti || (r_ei_pend && instr_boundary)) ? 1'b1 : r_ime;
      r_ei_pend   <= (ime_reset || w_ack) ? 1'b0 : ime_set ? 1'b1 : instr_boundary ? 1'b0 : r_ei_pend;
      r_vec_valid <= w_ack;
      r_vector    <= w_ack ? w_vec : r_vector;
      r_irq_clear <= w_clr;
    end
  end
  assign if_rdata  = r_if;
  assign ie_rdata  = r_ie;
  assign ime       = r_ime;
  assign wake      = |w_pend;
  assign int_req   = (r_state == ST_REQ);
  assign vec_valid = r_vec_valid;
  assign vector    = r_vector;
  assign irq_clear = r_irq_clear;
endmodule

// File: tb/tb_int_dispatch_unit.sv
// tb_int_dispatch_unit: directed scenarios plus randomized traffic scored against a behavioural model
module tb_int_dispatch_unit;
  localparam int N = 5;
  localparam logic [15:0] VB = 16'h0040;
  localparam logic [15:0] VS = 16'd8;
  logic clk4_2 = 1'b0;
  always #5 clk4_2 = ~clk4_2;
  logic reset, if_wr, ie_wr, ime_set, ime_reset, reti, instr_boundary, int_ack;
  logic [N-1:0] irq_req, if_wdata, ie_wdata, if_rdata, ie_rdata, irq_clear;
  logic int_req, vec_valid, ime, wake;
  logic [15:0] vector;
  logic q_ie_wr, q_if_wr, q_reti, q_ack, q_int_req, q_vec_valid, q_ime, q_wake;
  logic [7:0] q_ie_wdata, q_if_wdata, q_if_rdata, q_ie_rdata, q_irq_clear;
  logic [15:0] q_vector;
  int_dispatch_unit dut (
    .clk4_2(clk4_2), .reset(reset), .irq_req(irq_req), .if_wr(if_wr), .if_wdata(if_wdata),
    .ie_wr(ie_wr), .ie_wdata(ie_wdata), .if_rdata(if_rdata), .ie_rdata(ie_rdata),
    .ime_set(ime_set), .ime_reset(ime_reset), .reti(reti), .instr_boundary(instr_boundary),
    .int_req(int_req), .int_ack(int_ack), .vec_valid(vec_valid), .vector(vector),
    .irq_clear(irq_clear), .ime(ime), .wake(wake)
  );
  int_dispatch_unit #(.NUM_IRQ(8), .VEC_BASE(16'hFFF0), .VEC_STRIDE(16'd4)) u8 (
    .clk4_2(clk4_2), .reset(reset), .irq_req(8'h00), .if_wr(q_if_wr), .if_wdata(q_if_wdata),
    .ie_wr(q_ie_wr), .ie_wdata(q_ie_wdata), .if_rdata(q_if_rdata), .ie_rdata(q_ie_rdata),
    .ime_set(1'b0), .ime_reset(1'b0), .reti(q_reti), .instr_boundary(1'b0),
    .int_req(q_int_req), .int_ack(q_ack), .vec_valid(q_vec_valid), .vector(q_vector),
    .irq_clear(q_irq_clear), .ime(q_ime), .wake(q_wake)
  );
  typedef struct packed {logic [15:0] vec; logic [N-1:0] clr;} exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0, n_disp = 0;
  logic [N-1:0] m_if, m_ie, m_base, m_arb, m_clr;
  logic [15:0] m_vec;
  logic m_ime, m_pend, m_vv;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h at %0t", n, act, exp, $time);
    end
  endtask
  // winner is the lowest set index of IF&IE as seen in the ack cycle, including a same-cycle IF write
  always_comb begin
    m_base = if_wr ? if_wdata : m_if;
    m_arb = m_base & m_ie;
    m_clr = '0;
    m_vec = 16'h0000;
    for (int i = N - 1; i >= 0; i--)
      if (m_arb[i]) begin
        m_clr = N'(1) << i;
        m_vec = VB + 16'(i) * VS;
      end
  end
  always @(posedge clk4_2) begin
    if (reset) begin
      m_if <= '0; m_ie <= '0; m_ime <= 1'b0; m_pend <= 1'b0; m_vv <= 1'b0;
    end else begin
      if (int_ack) exp_q.push_back('{vec: m_vec, clr: m_clr});
      m_if <= irq_req | (m_base & ~(int_ack ? m_clr : '0));
      m_ie <= ie_wr ? ie_wdata : m_ie;
      m_vv <= int_ack;
      if (ime_reset || int_ack) begin
        m_ime <= 1'b0; m_pend <= 1'b0;
      end else begin
        if (reti || (m_pend && instr_boundary)) m_ime <= 1'b1;
        if (ime_set) m_pend <= 1'b1;
        else if (instr_boundary) m_pend <= 1'b0;
      end
    end
  end
  initial begin
    exp_t e;
    @(posedge clk4_2);
    forever begin
      @(negedge clk4_2);
      chk("if_rdata", 32'(if_rdata), 32'(m_if));
      chk("ie_rdata", 32'(ie_rdata), 32'(m_ie));
      chk("ime", 32'(ime), 32'(m_ime));
      chk("wake", 32'(wake), 32'(|(m_if & m_ie)));
      chk("vec_valid", 32'(vec_valid), 32'(m_vv));
      if (vec_valid === 1'b1 && m_vv) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_underflow act=vec_valid exp=no_dispatch at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("vector", 32'(vector), 32'(e.vec));
          chk("irq_clear", 32'(irq_clear), 32'(e.clr));
          n_disp++;
        end
      end else chk("irq_clear_idle", 32'(irq_clear), 32'd0);
    end
  end
  task automatic clear_inputs();
    reset = 0; irq_req = '0; if_wr = 0; if_wdata = '0; ie_wr = 0; ie_wdata = '0;
    ime_set = 0; ime_reset = 0; reti = 0; instr_boundary = 0; int_ack = 0;
    q_ie_wr = 0; q_if_wr = 0; q_reti = 0; q_ack = 0; q_ie_wdata = '0; q_if_wdata = '0;
  endtask
  task automatic step();
    @(posedge clk4_2);
    #1;
    clear_inputs();
  endtask
  task automatic do_reset();
    reset = 1;
    step();
  endtask
  initial begin
    clear_inputs();
    do_reset();
    chk("rst_int_req", 32'(int_req), 0);
    chk("rst_vector", 32'(vector), 0);
    // reset in the ack cycle wins over the dispatch
    ie_wr = 1; ie_wdata = 5'h1F; reti = 1; step();
    irq_req = 5'b00100; step();
    step();
    chk("rm_int_req", 32'(int_req), 1);
    int_ack = 1; reset = 1; step();
    chk("rm_int_req0", 32'(int_req), 0);
    chk("rm_vec_valid", 32'(vec_valid), 0);
    chk("rm_vector", 32'(vector), 0);
    chk("rm_clear", 32'(irq_clear), 0);
    chk("rm_if", 32'(if_rdata), 0);
    chk("rm_ime", 32'(ime), 0);
    // fixed priority picks source 1
    ie_wr = 1; ie_wdata = 5'h1F; if_wr = 1; if_wdata = 5'b10110; reti = 1; step();
    step();
    chk("pr_int_req", 32'(int_req), 1);
    int_ack = 1; step();
    chk("pr_vec_valid", 32'(vec_valid), 1);
    chk("pr_vector", 32'(vector), 32'h0048);
    chk("pr_clear", 32'(irq_clear), 32'b00010);
    chk("pr_if", 32'(if_rdata), 32'b10100);
    chk("pr_ime", 32'(ime), 0);
    chk("pr_int_req0", 32'(int_req), 0);
    step();
    chk("pr_vec_valid0", 32'(vec_valid), 0);
    chk("pr_clear0", 32'(irq_clear), 0);
    // EI takes effect on the first boundary after the EI cycle
    do_reset();
    ie_wr = 1; ie_wdata = 5'h1F; if_wr = 1; if_wdata = 5'b00001; step();
    ime_set = 1; instr_boundary = 1; step();
    chk("ei_ime_11", 32'(ime), 0);
    step(); step();
    chk("ei_ime_13", 32'(ime), 0);
    step();
    instr_boundary = 1; step();
    chk("ei_ime_15", 32'(ime), 1);
    chk("ei_req_15", 32'(int_req), 0);
    step();
    chk("ei_req_16", 32'(int_req), 1);
    // IF cleared by a write in the ack cycle gives an empty dispatch
    do_reset();
    ie_wr = 1; ie_wdata = 5'h1F; if_wr = 1; if_wdata = 5'b00100; reti = 1; step();
    step();
    chk("cx_int_req", 32'(int_req), 1);
    int_ack = 1; if_wr = 1; if_wdata = '0; step();
    chk("cx_vec_valid", 32'(vec_valid), 1);
    chk("cx_vector", 32'(vector), 0);
    chk("cx_clear", 32'(irq_clear), 0);
    chk("cx_ime", 32'(ime), 0);
    // hardware set beats a same-cycle CPU clear; wake ignores IME
    do_reset();
    irq_req = 5'b01000; if_wr = 1; if_wdata = '0; ie_wr = 1; ie_wdata = 5'b01000; step();
    chk("co_if", 32'(if_rdata), 32'b01000);
    chk("co_wake", 32'(wake), 1);
    chk("co_ime", 32'(ime), 0);
    ie_wr = 1; ie_wdata = 5'b00001; step();
    chk("co_wake0", 32'(wake), 0);
    // 8-source variant with wrapping vector arithmetic
    q_ie_wr = 1; q_ie_wdata = 8'hFF; q_if_wr = 1; q_if_wdata = 8'h80; q_reti = 1; step();
    step();
    chk("p8_int_req", 32'(q_int_req), 1);
    q_ack = 1; step();
    chk("p8_vec_valid", 32'(q_vec_valid), 1);
    chk("p8_vector", 32'(q_vector), 32'h000C);
    chk("p8_clear", 32'(q_irq_clear), 32'h80);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      irq_req = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if_wr = ($urandom_range(0, 15) == 0); if_wdata = N'($urandom);
      ie_wr = ($urandom_range(0, 31) == 0); ie_wdata = N'($urandom) | N'($urandom);
      ime_set = ($urandom_range(0, 9) == 0);
      ime_reset = ($urandom_range(0, 39) == 0);
      reti = ($urandom_range(0, 14) == 0);
      instr_boundary = ($urandom_range(0, 2) == 0);
      int_ack = int_req && ($urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    step(); step(); step();
    chk("disp_count_min", 32'(n_disp >= 20), 1);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/int_dispatch_unit.md
# int_dispatch_unit

Parametrised interrupt dispatcher for the CPU core, generalising the fixed five-source interrupt path. It provides:
- a per-source flag register (IF) and enable register (IE);
- the interrupt master enable (IME), including the one-instruction EI delay;
- fixed-priority arbitration and a req/ack handshake with the sequencer;
- a registered dispatch vector and one-hot clear pulses.

It sits between the peripheral interrupt requests and `cpu_control`, and replaces the IME flop and hard-coded vector writes in the datapath.

## Interface
Parameters:
- `NUM_IRQ`, 5, number of sources (1..8); source 0 has the highest priority.
- `VEC_BASE`, 16'h0040, vector of source 0.
- `VEC_STRIDE`, 8, address step between consecutive source vectors.

Ports:
- `clk4_2` in 1: core clock. All logic is sampled on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `irq_req` in NUM_IRQ: single-cycle set pulses from peripherals.
- `if_wr` in 1, `if_wdata` in NUM_IRQ: CPU write of IF.
- `ie_wr` in 1, `ie_wdata` in NUM_IRQ: CPU write of IE.
- `if_rdata` out NUM_IRQ, `ie_rdata` out NUM_IRQ: current register values.
- `ime_set` in 1: EI executed.
- `ime_reset` in 1: DI executed.
- `reti` in 1: RETI executed.
- `instr_boundary` in 1: pulses on the last cycle of every instruction.
- `int_req` out 1: dispatch request to the sequencer.
- `int_ack` in 1: sequencer accepts the dispatch.
- `vec_valid` out 1: one-cycle strobe marking a valid vector.
- `vector` out 16: dispatch address.
- `irq_clear` out NUM_IRQ: one-hot clear pulse to the serviced source.
- `ime` out 1: current IME value.
- `wake` out 1: HALT wake condition.

## Operation
- **Reset values:** IF=0, IE=0, IME=0, EI-pending=0, `int_req`=0, `vec_valid`=0, `vector`=0, `irq_clear`=0, FSM=IDLE. Reset has priority over every other input.
- **IF update, per bit, priority high→low:**
  - `irq_req` set;
  - dispatch clear;
  - `if_wr` data;
  - hold.
  - A hardware set in the same cycle as a CPU write or clear leaves the bit at 1.
- **IE:** loads `ie_wdata` on `ie_wr`, otherwise holds.
- **Pending vector:** P = IF & IE.
- **`wake`:** combinational |P, independent of IME and FSM state.
- **IME:**
  - `ime_reset` or a dispatch (ack) clears IME and EI-pending immediately.
  - `reti` sets IME immediately.
  - `ime_set` sets EI-pending. IME becomes 1 on the first `instr_boundary` strictly after the EI cycle.
  - `ime_set` together with `ime_reset`: `ime_reset` wins and EI-pending is cleared.
- **FSM states: IDLE, REQ, DISPATCH.**
  - IDLE→REQ when IME=1 and |P. `int_req`=1 from the next cycle.
  - REQ→IDLE without dispatch if IME drops (DI) or P becomes 0 before the ack.
  - REQ with `int_ack`→DISPATCH. The winner is the lowest set index of P *in the ack cycle*, which may differ from the index at request time.
  - If P=0 in the ack cycle (IF cleared by a write in that same cycle): `vector`=16'h0000, no `irq_clear`, IME still cleared.
  - DISPATCH→IDLE after one cycle.
- **Vector arithmetic:** vector = VEC_BASE + idx×VEC_STRIDE, computed at 16-bit width, with any carry out of bit 15 dropped.

## Timing
- `irq_req` at cycle t → IF bit set at t+1 → `int_req` at t+2, provided IME=1 and IE is set.
- `int_ack` sampled at cycle a:
  - at a+1: `vec_valid`=1, `vector` valid, `irq_clear` one-hot asserted, IF bit cleared, IME=0, `int_req`=0;
  - at a+2: `vec_valid` and `irq_clear` return to 0.
- `int_ack` outside REQ is ignored.
- Back-to-back: a new request may be raised no earlier than a+2, and only once IME is set again.
- `if_rdata`, `ie_rdata` and `ime` are register outputs with no combinational path from the inputs.

## Structure
- A shared package `int_pkg` holds:
  - the FSM state encoding (2 bits);
  - the default vector base and stride constants;
  - the `NUM_IRQ` maximum of 8.
- Sub-module `prio_enc_lsb`: a parametrised lowest-set-bit encoder returning index plus valid, used for arbitration and for building the one-hot clear.

## Test plan
- **Reset mid-dispatch:** with IE=5'h1F and IME=1, pulse `irq_req`=5'b00100, then assert `reset` in the ack cycle → all outputs 0 at the next cycle and IF=0.
- **Priority:** IE=5'h1F, IME=1, IF=5'b10110, ack → `vector`=16'h0048, `irq_clear`=5'b00010, IF=5'b10100, IME=0.
- **EI delay:** `ime_set` at cycle 10, `instr_boundary` at 10 and 14, IF&IE≠0 → IME=1 at cycle 15, `int_req` at 16.
- **Cancelled dispatch:** in REQ, `if_wr` with `if_wdata`=0 in the ack cycle → `vector`=16'h0000, `irq_clear`=0, IME=0.
- **Set/clear collision:** `irq_req[3]` and `if_wr` writing 0 in the same cycle → IF[3]=1. `wake`=1 with IME=0 whenever IE[3]=1.
- **Parameter variant:** NUM_IRQ=8, VEC_BASE=16'hFFF0, VEC_STRIDE=4, source 7 alone pending → `vector`=16'h000C (wrapped).
